aes_ctr_sequencer: RTL and testbench

- Sequences one AES-256 block-encryption core through a CTR-mode message of N 128-bit blocks.
- Generates counter blocks IV, IV+1, … and issues each to the core with a start/done handshake.
- Captures each keystream block, XORs it with the incoming plaintext block and emits ciphertext on a valid/ready stream.
- Sits between the message buffer/DMA and the AES core; the key goes to the core directly and must stay stable while busy.

---
 rtl/aes_ctr_pkg.sv | 29 ++
 rtl/aes_ctr_sequencer_if.sv | 52 +++++
 rtl/ctr_keystream_xor.sv | 20 ++
 rtl/aes_ctr_sequencer.sv | 146 ++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared types, widths and helpers for the AES-CTR sequencer and its datapath.
package aes_ctr_pkg;

  localparam int BLK_W = 128;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_AES,
    WAIT_IN,
    EMIT,
    FINISH
  } state_t;

  // Keep-mask for the final block: bytes 0..last_bytes-1 kept, the rest cleared.
  // Byte 0 is the most significant byte. last_bytes==0 means a full block.
  function automatic logic [BLK_W-1:0] mask_last(input logic [3:0] last_bytes);
    logic [BLK_W-1:0] m;
    m = '1;
    for (int b = 0; b < BLK_W / 8; b++) begin
      if (last_bytes != 4'd0 && b >= int'(last_bytes)) begin
        m[BLK_W-1-8*b -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/aes_ctr_sequencer_if.sv
// Bundle of the message-control, plaintext, ciphertext and AES-core signals.
//
// Stream handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. The source holds valid and data steady until that
// edge; ready may depend on state but never on valid of the same stream.
// Core handshake: aes_start is a one-cycle request, aes_block stays stable
// until the one-cycle aes_done pulse that carries aes_result.
interface aes_ctr_sequencer_if;
  import aes_ctr_pkg::*;

  logic             start;
  logic [BLK_W-1:0] iv;
  logic [LEN_W-1:0] num_blocks;
  logic [3:0]       last_bytes;
  logic             busy;
  logic             done;

  logic             in_valid;
  logic [BLK_W-1:0] in_data;
  logic             in_ready;

  logic             out_valid;
  logic [BLK_W-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  logic             aes_start;
  logic [BLK_W-1:0] aes_block;
  logic             aes_done;
  logic [BLK_W-1:0] aes_result;

  // Sequencer side.
  modport master (
    input  start, iv, num_blocks, last_bytes,
    input  in_valid, in_data, out_ready,
    input  aes_done, aes_result,
    output busy, done, in_ready,
    output out_valid, out_data, out_last,
    output aes_start, aes_block
  );

  // Environment side: message buffer, downstream sink and AES core.
  modport slave (
    output start, iv, num_blocks, last_bytes,
    output in_valid, in_data, out_ready,
    output aes_done, aes_result,
    input  busy, done, in_ready,
    input  out_valid, out_data, out_last,
    input  aes_start, aes_block
  );

endinterface

// File: rtl/ctr_keystream_xor.sv
// Combinational keystream XOR with final-block byte masking; shared with decrypt.
module ctr_keystream_xor
  import aes_ctr_pkg::*;
(
  input  logic [BLK_W-1:0] data,
  input  logic [BLK_W-1:0] ks,
  input  logic             last,
  input  logic [3:0]       last_bytes,
  output logic [BLK_W-1:0] result
);

  // Mask only applies to the final block of a message.
  always_comb begin
    result = data ^ ks;
    if (last) begin
      result = result & mask_last(last_bytes);
    end
  end

endmodule

// File: rtl/aes_ctr_sequencer.sv
// Drives one external AES-256 core through a CTR-mode message, one block at a time.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_ctr_sequencer_if.master bus,
  output state_t              dbg_state
);

  state_t           state;
  state_t           state_nxt;
  logic [BLK_W-1:0] ctr;
  logic [BLK_W-1:0] ks;
  logic [BLK_W-1:0] out_data_r;
  logic [BLK_W-1:0] xor_out;
  logic [LEN_W-1:0] rem;
  logic [3:0]       lb;
  logic             busy_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             is_last;

  assign is_last   = (rem == LEN_W'(1));
  assign dbg_state = state;

  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  // ctr only moves in IDLE and EMIT, so it is stable for the whole core request.
  assign bus.aes_block = ctr;

  ctr_keystream_xor u_xor (
    .data       (bus.in_data),
    .ks         (ks),
    .last       (is_last),
    .last_bytes (lb),
    .result     (xor_out)
  );

  // State register; reset aborts any message and drops back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded strobes; in_ready depends on state only.
  always_comb begin
    state_nxt     = state;
    bus.aes_start = 1'b0;
    bus.in_ready  = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.num_blocks == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        bus.aes_start = 1'b1;
        state_nxt     = WAIT_AES;
      end
      WAIT_AES: begin
        if (bus.aes_done) begin
          state_nxt = WAIT_IN;
        end
      end
      WAIT_IN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_nxt = is_last ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Message registers: counter, remaining count, keystream and output holding stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr         <= '0;
      rem         <= '0;
      lb          <= '0;
      ks          <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ctr    <= bus.iv;
            rem    <= bus.num_blocks;
            lb     <= bus.last_bytes;
            busy_r <= 1'b1;
          end
        end
        WAIT_AES: begin
          if (bus.aes_done) begin
            ks <= bus.aes_result;
          end
        end
        WAIT_IN: begin
          if (bus.in_valid) begin
            out_data_r  <= xor_out;
            out_valid_r <= 1'b1;
            out_last_r  <= is_last;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            rem         <= rem - LEN_W'(1);
            if (!is_last) begin
              // Plain modular increment: all-ones wraps to zero.
              ctr <= ctr + BLK_W'(1);
            end
          end
        end
        FINISH: begin
          busy_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Self-checking bench for aes_ctr_sequencer with a stand-in AES core and CTR reference model.
module tb_aes_ctr_sequencer;
  import aes_ctr_pkg::*;

  localparam int W = BLK_W + 1;

  localparam logic [127:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] NIST_PT [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710
  };
  localparam logic [127:0] NIST_CT [4] = '{
    128'h601ec313775789a5b7a7f504bbf3d228,
    128'hf443e3ca4d62b59aca84e990cacaf5c5,
    128'h2b0930daa23de94ce87017ba2d84988d,
    128'hdfc9c58db67aada613c2dd08457941a6
  };

  logic   clk;
  logic   rst;
  state_t dbg_state;

  aes_ctr_sequencer_if bus ();

  aes_ctr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Scoreboard and environment state.
  logic [W-1:0]     exp_q[$];
  logic [BLK_W-1:0] exp_ctr_q[$];
  logic [BLK_W-1:0] pt_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int start_seen_cnt = 0;
  int ks_avail = 0;
  int core_cnt = 0;
  int core_lat_lo = 1;
  int core_lat_hi = 4;
  int in_delay = 0;
  int out_mode = 0;
  bit stray_req = 0;
  bit hold_valid = 0;
  logic [W-1:0]     hold_val;
  logic [BLK_W-1:0] core_blk;
  logic [BLK_W-1:0] last_out;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish within bound");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in AES core: the published F.5.5 keystream for the reference counters,
  // an arbitrary fixed scramble for any other counter block.
  function automatic logic [127:0] core_fn(input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      if (blk == NIST_IV + 128'(i)) return NIST_PT[i] ^ NIST_CT[i];
    end
    return {blk[63:0] ^ 64'h9e3779b97f4a7c15, ~blk[127:64]};
  endfunction

  // ---------------- environment: monitors + AES core model ----------------
  always @(negedge clk) begin : env
    logic [W-1:0] e;
    if (rst) begin
      core_cnt     = 0;
      ks_avail     = 0;
      hold_valid   = 0;
      bus.aes_done = 1'b0;
    end else begin
      // Plaintext is accepted only while a fresh keystream block is waiting.
      check_eq("in_ready", bus.in_ready, ks_avail > 0);
      if (bus.in_valid && bus.in_ready) ks_avail--;

      if (hold_valid) check_eq("out_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, hold_val});
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_val   = {bus.out_last, bus.out_data};

      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_unexpected", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", bus.out_data, e[BLK_W-1:0]);
          check_eq("out_last", bus.out_last, e[BLK_W]);
        end
        last_out = bus.out_data;
      end

      if (bus.done) done_cnt++;

      bus.aes_done = 1'b0;
      if (stray_req) begin
        bus.aes_done   = 1'b1;
        bus.aes_result = rand128();
        stray_req      = 0;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          check_eq("aes_block_hold", bus.aes_block, core_blk);
          bus.aes_done   = 1'b1;
          bus.aes_result = core_fn(core_blk);
          ks_avail++;
        end
      end

      if (bus.aes_start) begin
        start_seen_cnt++;
        if (exp_ctr_q.size() == 0) begin
          check_eq("aes_start_unexpected", bus.aes_start, 1'b0);
        end else begin
          check_eq("aes_block", bus.aes_block, exp_ctr_q.pop_front());
        end
        check_eq("issue_while_out_valid", bus.out_valid, 1'b0);
        core_blk = bus.aes_block;
        core_cnt = int'($urandom_range(core_lat_lo, core_lat_hi));
      end
    end
  end

  // ---------------- upstream plaintext driver ----------------
  initial begin : feeder
    logic [127:0] pt;
    bit accepted;
    bit aborted;
    forever begin
      @(posedge clk); #1;
      if (!rst && pt_q.size() > 0) begin
        pt = pt_q.pop_front();
        repeat (in_delay) @(posedge clk);
        if (in_delay > 0) #1;
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        accepted = 0;
        aborted  = 0;
        for (int c = 0; c < 4000 && !accepted && !aborted; c++) begin
          @(negedge clk);
          if (rst) aborted = 1;
          else if (bus.in_ready) accepted = 1;
        end
        if (!accepted && !aborted) check_eq("in_accept_timeout", bus.in_ready, 1'b1);
        if (accepted) begin
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = rand128();
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin : sink
    int vcnt;
    vcnt = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.out_valid) vcnt++;
      else vcnt = 0;
      if (out_mode == 1) bus.out_ready = (vcnt > 10);
      else bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Reference model: counter i is iv+i mod 2^128; ciphertext is pt ^ E(counter),
  // with bytes last_bytes..15 of the final block cleared when last_bytes != 0.
  task automatic expect_msg(input logic [127:0] iv, input int n, input logic [3:0] lb, input bit nist);
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] c;
    for (int i = 0; i < n; i++) begin
      c = iv + 128'(i);
      exp_ctr_q.push_back(c);
      if (nist) begin
        pt = NIST_PT[i];
        ct = NIST_CT[i];
      end else begin
        pt = rand128();
        ct = pt ^ core_fn(c);
        if (i == n - 1 && lb != 4'd0) ct = ct & ~({128{1'b1}} >> (8 * int'(lb)));
      end
      pt_q.push_back(pt);
      exp_q.push_back({(i == n - 1), ct});
    end
  endtask

  task automatic pulse_start(input logic [127:0] iv, input logic [15:0] n, input logic [3:0] lb);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.iv         = iv;
    bus.num_blocks = n;
    bus.last_bytes = lb;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.iv         = ~iv;
    bus.num_blocks = ~n;
    bus.last_bytes = ~lb;
  endtask

  task automatic wait_done(input int db, input int sb, input int n);
    for (int c = 0; c < 4000 && done_cnt == db; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    check_eq("done_count", done_cnt - db, 1);
    check_eq("aes_start_count", start_seen_cnt - sb, n);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("ctr_q_drained", exp_ctr_q.size(), 0);
    @(negedge clk);
    check_eq("busy_after_done", bus.busy, 1'b0);
  endtask

  task automatic run_msg(input logic [127:0] iv, input int n, input logic [3:0] lb, input bit nist);
    int db;
    int sb;
    db = done_cnt;
    sb = start_seen_cnt;
    expect_msg(iv, n, lb, nist);
    pulse_start(iv, 16'(n), lb);
    wait_done(db, sb, n);
  endtask

  task automatic do_reset(input int cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    pt_q.delete();
    exp_q.delete();
    exp_ctr_q.delete();
    repeat (cyc) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq(tag, {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.out_last,
                   bus.aes_start, bus.out_data, bus.aes_block}, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int db;
    int sb;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.iv         = '0;
    bus.num_blocks = '0;
    bus.last_bytes = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_aes_start", bus.aes_start, 1'b0);
    check_idle_outputs("rst_outputs");
    @(posedge clk); #1 rst = 1'b0;

    // NIST SP800-38A F.5.5 message.
    run_msg(NIST_IV, 4, 4'd0, 1'b1);

    // Counter wrap across 2^128.
    run_msg(128'hfffffffffffffffffffffffffffffffe, 3, 4'd0, 1'b0);

    // Partial final block of 5 bytes.
    run_msg(rand128(), 1, 4'd5, 1'b0);
    check_eq("partial_low_zero", last_out[87:0], 88'h0);

    // Backpressure: late plaintext, downstream stalled for 10 cycles per block.
    in_delay = 7;
    out_mode = 1;
    run_msg(rand128(), 2, 4'd0, 1'b0);
    in_delay = 0;
    out_mode = 0;

    // Zero-length message; a start held into FINISH must be ignored.
    db = done_cnt;
    sb = start_seen_cnt;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.iv         = rand128();
    bus.num_blocks = 16'd0;
    bus.last_bytes = 4'd0;
    @(posedge clk); #1;
    bus.num_blocks = 16'd2;
    @(negedge clk);
    check_eq("zero_len_done", bus.done, 1'b1);
    check_eq("zero_len_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("zero_len_done_drop", bus.done, 1'b0);
    check_eq("finish_start_ignored", bus.busy, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("zero_len_no_issue", start_seen_cnt - sb, 0);
    check_eq("zero_len_done_count", done_cnt - db, 1);

    // Start while busy is ignored; the latched counter keeps running.
    db = done_cnt;
    sb = start_seen_cnt;
    begin
      logic [127:0] iv_a;
      iv_a = rand128();
      expect_msg(iv_a, 3, 4'd0, 1'b0);
      pulse_start(iv_a, 16'd3, 4'd0);
      for (int c = 0; c < 500 && start_seen_cnt == sb; c++) @(posedge clk);
      pulse_start(~iv_a, 16'd5, 4'd7);
      wait_done(db, sb, 3);
    end

    // Reset during the core wait of block 2, then a stray aes_done.
    core_lat_lo = 20;
    core_lat_hi = 20;
    db = done_cnt;
    sb = start_seen_cnt;
    begin
      logic [127:0] iv_r;
      iv_r = rand128();
      expect_msg(iv_r, 3, 4'd0, 1'b0);
      pulse_start(iv_r, 16'd3, 4'd0);
    end
    for (int c = 0; c < 500 && start_seen_cnt < sb + 2; c++) @(posedge clk);
    check_eq("rst_reached_blk2", start_seen_cnt - sb, 2);
    repeat (3) @(posedge clk);
    do_reset(2);
    stray_req = 1;
    repeat (6) begin
      @(negedge clk);
      check_idle_outputs("rst_mid_outputs");
    end
    check_eq("rst_mid_no_done", done_cnt - db, 0);
    core_lat_lo = 1;
    core_lat_hi = 4;
    run_msg(rand128(), 2, 4'd3, 1'b0);

    // Randomized messages.
    for (int m = 0; m < 10; m++) begin
      core_lat_lo = 1;
      core_lat_hi = int'($urandom_range(1, 6));
      in_delay    = int'($urandom_range(0, 3));
      out_mode    = 0;
      run_msg(rand128(), int'($urandom_range(1, 6)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
